agu_stream: RTL

Parametrised streaming address generation unit: the successor to the single-register, free-running AGU. Once per job it latches a base, a signed stride, an element count and an optional circular-buffer length, then emits one address per accepted valid/ready handshake until the count is exhausted or the job is aborted. It sits between the load/store sequencer, which issues jobs, and the memory request port, which consumes addresses.

---
 rtl/agu_pkg.sv | 13 +
 rtl/agu_offset_step.sv | 34 +++
 rtl/agu_stream.sv | 105 ++++++++++
 3 files changed

// File: rtl/agu_pkg.sv
// Shared types and default widths for the streaming address generation unit.
package agu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } agu_state_t;

  localparam int unsigned AGU_ADDR_W_DEF = 64;
  localparam int unsigned AGU_CNT_W_DEF  = 16;

endpackage

// File: rtl/agu_offset_step.sv
// Combinational next-offset step: linear add, plus an optional circular wrap when
// AGU_STREAM_WRAP_EN is defined.
module agu_offset_step
  import agu_pkg::*;
#(
  parameter int unsigned ADDR_W = AGU_ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_offset,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic              i_wrap_en,
  input  logic [ADDR_W-1:0] i_wrap_len,
  output logic [ADDR_W-1:0] o_next_offset
);

  logic [ADDR_W-1:0] w_sum;

  assign w_sum = i_offset + i_stride;

`ifdef AGU_STREAM_WRAP_EN
  // A zero wrap length falls back to linear stepping.
  always_comb begin
    o_next_offset = w_sum;
    if (i_wrap_en && (i_wrap_len != '0) && (w_sum >= i_wrap_len)) begin
      o_next_offset = w_sum - i_wrap_len;
    end
  end
`else
  logic w_unused_wrap;

  assign w_unused_wrap = i_wrap_en ^ (^i_wrap_len);
  assign o_next_offset = w_sum;
`endif

endmodule

// File: rtl/agu_stream.sv
// Streaming AGU: latches a job on start, emits one address per valid/ready handshake.
// Circular-buffer stepping is built only when AGU_STREAM_WRAP_EN is defined.
module agu_stream
  import agu_pkg::*;
#(
  parameter int unsigned ADDR_W = AGU_ADDR_W_DEF,
  parameter int unsigned CNT_W  = AGU_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_cfg_base,
  input  logic [ADDR_W-1:0] i_cfg_stride,
  input  logic [CNT_W-1:0]  i_cfg_count,
  input  logic              i_cfg_wrap_en,
  input  logic [ADDR_W-1:0] i_cfg_wrap_len,
  input  logic              i_abort,
  output logic              o_addr_valid,
  input  logic              i_addr_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_addr_last,
  output logic              o_busy,
  output logic              o_done
);

  agu_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_base, r_stride, r_wrap_len, r_offset;
  logic              r_wrap_en;
  logic [CNT_W-1:0]  r_count, r_idx;
  logic [ADDR_W-1:0] w_next_offset;
  logic              w_last, w_hs, w_accept;

  assign w_last   = (r_idx == (r_count - CNT_W'(1)));
  assign w_hs     = (r_state == StRun) && i_addr_ready;
  assign w_accept = (r_state == StIdle) && i_start && (i_cfg_count != '0);

  agu_offset_step #(
    .ADDR_W(ADDR_W)
  ) u_step (
    .i_offset     (r_offset),
    .i_stride     (r_stride),
    .i_wrap_en    (r_wrap_en),
    .i_wrap_len   (r_wrap_len),
    .o_next_offset(w_next_offset)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_cfg_count != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (i_abort || (w_hs && w_last)) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_addr_valid = (r_state == StRun);
    o_addr       = o_addr_valid ? (r_base + r_offset) : '0;
    o_addr_last  = o_addr_valid && w_last;
    o_busy       = (r_state != StIdle);
    o_done       = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_stride   <= '0;
      r_count    <= '0;
      r_wrap_en  <= 1'b0;
      r_wrap_len <= '0;
      r_offset   <= '0;
      r_idx      <= '0;
    end else if (w_accept) begin
      r_base     <= i_cfg_base;
      r_stride   <= i_cfg_stride;
      r_count    <= i_cfg_count;
      r_wrap_en  <= i_cfg_wrap_en;
      r_wrap_len <= i_cfg_wrap_len;
      r_offset   <= '0;
      r_idx      <= '0;
    end else if (w_hs && !w_last && !i_abort) begin
      // Abort exits RUN this edge, so the step state need not advance.
      r_offset <= w_next_offset;
      r_idx    <= r_idx + CNT_W'(1);
    end
  end

endmodule
